// File: rtl/mtl2_video_rx.sv
// Receive-side monitor for the MTL2 panel video stream: recovers pixel
// coordinates, checks line width and frame height, tracks lock, and captures
// the RGB value at a programmable probe coordinate.
module mtl2_video_rx #(
    parameter int H_ACTIVE        = 800,
    parameter int V_ACTIVE        = 480,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        data_enable,
    input  logic [23:0] rgb_in,
    input  logic [11:0] probe_x,
    input  logic [11:0] probe_y,
    input  logic        err_clr,
    output logic        rx_de,
    output logic [11:0] rx_x,
    output logic [11:0] rx_y,
    output logic        frame_start,
    output logic        locked,
    output logic        err_hwidth,
    output logic        err_vlines,
    output logic [23:0] probe_rgb,
    output logic        probe_valid
);

    typedef enum logic [1:0] {
        ST_UNSYNC  = 2'd0,
        ST_SYNCING = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [11:0] CNT_MAX  = 12'hFFF;
    localparam logic [11:0] H_EXP    = 12'(H_ACTIVE);
    localparam logic [11:0] V_EXP    = 12'(V_ACTIVE);
    localparam logic [7:0]  LOCK_EXP = 8'(LOCK_FRAMES);

    state_t      state_r, state_nxt_s;
    logic [7:0]  clean_cnt_r, clean_nxt_s;
    logic        hs_prev_r, vs_prev_r, de_prev_r, live_r;
    logic [11:0] cx_r, cy_r, run_r;
    logic        line_ok_r, bad_r;

    logic        hs_s, vs_s, hs_edge_s, vs_edge_s, de_rise_s, de_fall_s;
    logic        line_end_s, width_err_s, vlines_err_s, frame_bad_s, probe_hit_s;
    logic [11:0] cx_cur_s, cy_cur_s, cy_line_s, cx_nxt_s, cy_nxt_s, run_nxt_s;
    logic        line_ok_nxt_s;

    // live_r masks the first cycle after reset so stale history cannot fake an edge
    assign hs_s      = (SYNC_ACTIVE_LOW != 0) ? ~hsync : hsync;
    assign vs_s      = (SYNC_ACTIVE_LOW != 0) ? ~vsync : vsync;
    assign hs_edge_s = hs_s & ~hs_prev_r & live_r;
    assign vs_edge_s = vs_s & ~vs_prev_r & live_r;
    assign de_rise_s = data_enable & ~de_prev_r & live_r;
    assign de_fall_s = ~data_enable & de_prev_r;

    // Coordinate, run-length and frame-quality next-state logic
    always_comb begin
        cx_cur_s      = hs_edge_s ? 12'd0 : cx_r;
        cy_cur_s      = vs_edge_s ? 12'd0 : cy_r;
        line_end_s    = de_fall_s & line_ok_r;
        width_err_s   = line_end_s & (run_r != H_EXP);
        cy_line_s     = (line_end_s && (cy_r != CNT_MAX)) ? cy_r + 12'd1 : cy_r;
        vlines_err_s  = vs_edge_s & (state_r != ST_UNSYNC) & (cy_line_s != V_EXP);
        frame_bad_s   = bad_r | width_err_s | ((state_r != ST_UNSYNC) && (cy_line_s != V_EXP));
        cx_nxt_s      = (data_enable && (cx_cur_s != CNT_MAX)) ? cx_cur_s + 12'd1 : cx_cur_s;
        cy_nxt_s      = vs_edge_s ? 12'd0 : cy_line_s;
        probe_hit_s   = data_enable & (cx_cur_s == probe_x) & (cy_cur_s == probe_y);
        run_nxt_s     = run_r;
        line_ok_nxt_s = line_ok_r;
        // A line still open at vsync is abandoned: no width check, no row count
        if (vs_edge_s) begin
            run_nxt_s     = 12'd0;
            line_ok_nxt_s = data_enable ? 1'b0 : line_ok_r;
        end else if (de_fall_s) begin
            run_nxt_s     = 12'd0;
            line_ok_nxt_s = 1'b0;
        end else begin
            run_nxt_s     = (data_enable && (run_r != CNT_MAX)) ? run_r + 12'd1 : run_r;
            line_ok_nxt_s = de_rise_s ? 1'b1 : line_ok_r;
        end
    end

    // Lock state machine: frames are judged only at vsync assertion edges
    always_comb begin
        state_nxt_s = state_r;
        clean_nxt_s = clean_cnt_r;
        if (vs_edge_s) begin
            case (state_r)
                ST_UNSYNC: begin
                    state_nxt_s = ST_SYNCING;
                    clean_nxt_s = 8'd0;
                end
                ST_SYNCING: begin
                    if (frame_bad_s) begin
                        state_nxt_s = ST_SYNCING;
                        clean_nxt_s = 8'd0;
                    end else begin
                        clean_nxt_s = clean_cnt_r + 8'd1;
                        state_nxt_s = ((clean_cnt_r + 8'd1) >= LOCK_EXP) ? ST_LOCKED : ST_SYNCING;
                    end
                end
                ST_LOCKED: begin
                    if (frame_bad_s) begin
                        state_nxt_s = ST_SYNCING;
                        clean_nxt_s = 8'd0;
                    end else begin
                        state_nxt_s = ST_LOCKED;
                        clean_nxt_s = clean_cnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_UNSYNC;
                    clean_nxt_s = 8'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            clean_nxt_s = clean_cnt_r;
        end
    end

    // Input history and pixel/line counters
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev_r <= 1'b0;
            vs_prev_r <= 1'b0;
            de_prev_r <= 1'b0;
            live_r    <= 1'b0;
            cx_r      <= 12'd0;
            cy_r      <= 12'd0;
            run_r     <= 12'd0;
            line_ok_r <= 1'b0;
            bad_r     <= 1'b0;
        end else begin
            hs_prev_r <= hs_s;
            vs_prev_r <= vs_s;
            de_prev_r <= data_enable;
            live_r    <= 1'b1;
            cx_r      <= cx_nxt_s;
            cy_r      <= cy_nxt_s;
            run_r     <= run_nxt_s;
            line_ok_r <= line_ok_nxt_s;
            bad_r     <= vs_edge_s ? 1'b0 : (bad_r | width_err_s);
        end
    end

    // Lock state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_UNSYNC;
            clean_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_nxt_s;
            clean_cnt_r <= clean_nxt_s;
        end
    end

    // Registered outputs; a new error outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_de       <= 1'b0;
            rx_x        <= 12'd0;
            rx_y        <= 12'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err_hwidth  <= 1'b0;
            err_vlines  <= 1'b0;
            probe_rgb   <= 24'd0;
            probe_valid <= 1'b0;
        end else begin
            rx_de       <= data_enable;
            rx_x        <= cx_cur_s;
            rx_y        <= cy_cur_s;
            frame_start <= vs_edge_s;
            locked      <= (state_nxt_s == ST_LOCKED);
            err_hwidth  <= width_err_s  ? 1'b1 : (err_clr ? 1'b0 : err_hwidth);
            err_vlines  <= vlines_err_s ? 1'b1 : (err_clr ? 1'b0 : err_vlines);
            probe_rgb   <= probe_hit_s ? rgb_in : probe_rgb;
            probe_valid <= probe_hit_s;
        end
    end

endmodule

// File: tb/tb_mtl2_video_rx.sv
// Self-checking bench for mtl2_video_rx on a reduced geometry, with a
// frame-level reference model of lock, error and probe behaviour.
module tb_mtl2_video_rx;

    localparam int H_A   = 24;
    localparam int V_A   = 8;
    localparam int LOCKF = 2;
    localparam int PX    = 10;
    localparam int PY    = 5;

    logic        clk = 1'b0;
    logic        reset, hsync, vsync, data_enable, err_clr;
    logic [23:0] rgb_in;
    logic [11:0] probe_x, probe_y;
    logic        rx_de, frame_start, locked, err_hwidth, err_vlines, probe_valid;
    logic [11:0] rx_x, rx_y;
    logic [23:0] probe_rgb;

    int total = 0;
    int bad   = 0;

    // Reference model state (frame-level view of the stream)
    bit          m_first, m_vs_prev, m_sync, m_locked, m_eh, m_ev, m_fbad;
    int          m_clean, m_row;
    logic [23:0] m_prgb;

    mtl2_video_rx #(
        .H_ACTIVE(H_A), .V_ACTIVE(V_A), .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(LOCKF)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .data_enable(data_enable), .rgb_in(rgb_in), .probe_x(probe_x),
        .probe_y(probe_y), .err_clr(err_clr), .rx_de(rx_de), .rx_x(rx_x),
        .rx_y(rx_y), .frame_start(frame_start), .locked(locked),
        .err_hwidth(err_hwidth), .err_vlines(err_vlines),
        .probe_rgb(probe_rgb), .probe_valid(probe_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_sync = 1'b0; m_locked = 1'b0; m_clean = 0; m_row = 0;
        m_eh = 1'b0; m_ev = 1'b0; m_fbad = 1'b0; m_prgb = 24'd0;
    endfunction

    // Judge the frame that just ended and advance the lock bookkeeping
    function automatic void frame_eval();
        bit short_frame;
        short_frame = m_sync && (m_row != V_A);
        if (short_frame) m_ev = 1'b1;
        if (!m_sync) begin
            m_sync = 1'b1; m_clean = 0;
        end else if (m_fbad || short_frame) begin
            m_clean = 0; m_locked = 1'b0;
        end else if (!m_locked) begin
            m_clean++;
            if (m_clean >= LOCKF) m_locked = 1'b1;
        end
        m_row = 0; m_fbad = 1'b0;
    endfunction

    // One clock: drive on the falling edge, check 1 ns after the rising edge
    task automatic tick(input bit hs_a, input bit vs_a, input bit de_a, input logic [23:0] rgb,
                        input bit clr, input bit rst, input bit hw_new, input bit exp_pv);
        bit exp_fs;
        @(negedge clk);
        hsync = ~hs_a; vsync = ~vs_a; data_enable = de_a; rgb_in = rgb;
        err_clr = clr; reset = rst;
        exp_fs = vs_a && !m_vs_prev && !m_first && !rst;
        if (rst) model_reset();
        else begin
            if (clr) begin m_eh = 1'b0; m_ev = 1'b0; end
            if (hw_new) m_eh = 1'b1;
            if (exp_fs) frame_eval();
        end
        @(posedge clk); #1;
        check("rx_de", 32'(rx_de), 32'(de_a && !rst));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
        check("locked", 32'(locked), 32'(m_locked));
        check("err_hwidth", 32'(err_hwidth), 32'(m_eh));
        check("err_vlines", 32'(err_vlines), 32'(m_ev));
        check("probe_valid", 32'(probe_valid), 32'(exp_pv && !rst));
        check("probe_rgb", 32'(probe_rgb), 32'(m_prgb));
        if (rst) begin
            check("rx_x_rst", 32'(rx_x), 32'd0);
            check("rx_y_rst", 32'(rx_y), 32'd0);
        end
        m_first = rst;
        m_vs_prev = rst ? 1'b0 : vs_a;
    endtask

    // One line: hsync pulse, back porch, w DE pixels, then front porch
    task automatic send_line(input int w, input bit clr_at_fall, input int rst_at);
        bit seen, hit, hw_bad;
        int xo, x;
        logic [23:0] rgb;
        seen = 1'b1; xo = 0;
        tick(1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < w; i++) begin
            if (i == rst_at) begin
                tick(1'b0, 1'b0, 1'b1, 24'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
                seen = 1'b0; xo = i + 1;
            end else begin
                x = i - xo;
                hit = (x == PX) && (m_row == PY);
                rgb = hit ? 24'h00CC00 : 24'($urandom);
                if (hit) m_prgb = rgb;
                tick(1'b0, 1'b0, 1'b1, rgb, 1'b0, 1'b0, 1'b0, hit);
                check("rx_x", 32'(rx_x), 32'(x));
                check("rx_y", 32'(rx_y), 32'(m_row));
            end
        end
        hw_bad = seen && (w != H_A);
        if (hw_bad) m_fbad = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 24'd0, clr_at_fall, 1'b0, hw_bad, 1'b0);
        if (seen) m_row++;
        for (int k = 0; k < int'($urandom_range(3, 1)); k++)
            tick(1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One frame: vsync (with a coincident hsync edge), then nlines lines
    task automatic send_frame(input int nlines, input int short_idx, input int clr_idx, input int rst_line);
        tick(1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int l = 0; l < nlines; l++)
            send_line((l == short_idx) ? H_A - 1 : H_A, l == clr_idx, (l == rst_line) ? 5 : -1);
        for (int k = 0; k < 3; k++)
            tick(1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; hsync = 1'b1; vsync = 1'b1; data_enable = 1'b0;
        rgb_in = 24'd0; err_clr = 1'b0;
        probe_x = 12'(PX); probe_y = 12'(PY);
        m_first = 1'b1; m_vs_prev = 1'b0;
        model_reset();

        // Reset state
        for (int k = 0; k < 3; k++)
            tick(1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Nominal frames: lock after the third vsync edge
        for (int f = 0; f < 3; f++) send_frame(V_A, -1, -1, -1);
        // Short line while locked: lock holds until the next vsync edge
        send_frame(V_A, 2, -1, -1);
        // Relock after two further clean frames
        for (int f = 0; f < 3; f++) send_frame(V_A, -1, -1, -1);
        tick(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Frame one line short, judged at the following vsync edge
        send_frame(V_A - 1, -1, -1, -1);
        // Clear coinciding with a width error: the error wins
        send_frame(V_A, 1, 1, -1);
        tick(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) send_frame(V_A, -1, -1, -1);
        // Reset mid-line while locked, then resynchronise
        send_frame(V_A, -1, -1, 2);
        for (int f = 0; f < 3; f++) send_frame(V_A, -1, -1, -1);
        send_frame(0, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mtl2_video_rx.md
Name: mtl2_video_rx

Overview:
Receive-side monitor for the MTL2 panel video interface. It consumes the same DCLK-domain hsync/vsync/data-enable/RGB stream our pixel generators drive, recovers the pixel coordinates, and checks line width and frame height against the expected geometry. It reports lock status and sticky timing errors, and captures the RGB value at a programmable probe coordinate. It sits on the loop-back/verification path beside the panel driver and is used for on-board self-test of generated graphics.

Parameters:
H_ACTIVE, 800, expected active pixels per line (data_enable run length)
V_ACTIVE, 480, expected active lines per frame
SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low (MTL2 HSD/VSD), 0 = asserted high
LOCK_FRAMES, 2, consecutive clean frames required to assert lock

Ports:
clk  in  1  pixel clock (same as MTL2_DCLK); all logic on rising edge
reset  in  1  synchronous, active-high
hsync  in  1  horizontal sync from the video source
vsync  in  1  vertical sync from the video source
data_enable  in  1  active-pixel qualifier
rgb_in  in  24  {R[7:0],G[7:0],B[7:0]}, valid when data_enable=1
probe_x  in  12  column to sample
probe_y  in  12  row to sample
err_clr  in  1  one-cycle pulse clears sticky errors
rx_de  out  1  data_enable delayed one cycle
rx_x  out  12  column of the pixel in the rx_de cycle
rx_y  out  12  row of the pixel in the rx_de cycle
frame_start  out  1  one-cycle pulse on vsync assertion edge
locked  out  1  geometry verified for LOCK_FRAMES frames
err_hwidth  out  1  sticky: a line's DE run length != H_ACTIVE
err_vlines  out  1  sticky: a frame's active line count != V_ACTIVE
probe_rgb  out  24  last captured pixel at (probe_x, probe_y)
probe_valid  out  1  one-cycle pulse when probe_rgb updates

Behaviour:
- Reset values: every output is 0. Counters are 0. State is UNSYNC.
- Sync decode: hs and vs are normalised to active-high using SYNC_ACTIVE_LOW, then registered once. The assertion edge is cur=1 and prev=0. The first cycle after reset never produces an edge.
- Column counter cx: cleared on the hs edge. When data_enable=1, cx increments (saturates at 4095). The pixel's coordinate is the value before the increment.
- DE run length: counted per line. On the DE falling edge (de_prev=1, de=0), the run length is compared with H_ACTIVE. A mismatch sets err_hwidth and marks the frame bad. The active line counter cy then increments (saturates).
- rx_x/rx_y/rx_de are registered, giving 1-cycle latency from the input pixel.
- vs edge:
  - frame_start pulses.
  - If state is not UNSYNC, cy is compared with V_ACTIVE. A mismatch sets err_vlines and marks the frame bad.
  - cy and cx are then cleared. The bad-frame flag is cleared after it has been evaluated.
- Row coordinate is cy as it stands during the line (0 for the first active line after vsync).
- State machine:
  - UNSYNC -> SYNCING on the first vs edge. clean_cnt=0.
  - SYNCING: at each vs edge, a clean frame increments clean_cnt and a bad frame sets clean_cnt=0. When clean_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: locked=1. A bad frame at a vs edge drops to SYNCING with clean_cnt=0. Mid-frame errors do not drop lock until the vs edge.
- Sticky errors: err_hwidth and err_vlines hold until err_clr=1. If err_clr and a new error occur in the same cycle, the new error wins (flag ends at 1). err_clr has no effect on lock state.
- Probe: when data_enable=1 and the current (cx, cy) equals (probe_x, probe_y), rgb_in is latched into probe_rgb with probe_valid=1 on the next cycle. Otherwise probe_rgb holds its value. Probe capture is active in every state.
- Simultaneous hs and vs edges: both are processed. cx and cy are cleared and frame evaluation uses the pre-clear cy.
- DE still high at a vs edge: the partial line is discarded without a width check. The run counter is cleared.
- Reset mid-frame: everything returns to reset values and the next vs edge is treated as the first.

Test Plan:
- Nominal 800x480 frames, active-low syncs: after the 3rd vsync edge, locked=1. Both errors stay 0. rx_x goes 0..799 and rx_y 0..479, each exactly 1 cycle after the input.
- Probe at (10, 5), with the source driving rgb=0x00CC00 only at that pixel and 0xCCCCCC elsewhere: probe_valid pulses once per frame and probe_rgb=0x00CC00.
- One line with a 799-pixel DE run in frame 4 while locked: err_hwidth=1 at the end of that line. locked stays 1 until the next vsync edge, then drops to 0. It reasserts after 2 further clean frames.
- A frame of 479 lines: err_vlines=1 at the vsync edge and locked=0. Pulse err_clr: both flags return to 0.
- err_clr asserted in the same cycle as a width error: err_hwidth ends at 1.
- Assert reset mid-line in LOCKED: all outputs are 0 on the next cycle. After release, no frame_start occurs until a real vsync edge. The first frame after that edge is not checked for line count.
